arith_ctrl: RTL and testbench

Sequencer directly upstream of `arith_unit`:
- Accepts an arithmetic command and fetches two operands through `arith_unit`'s C register via a memory read handshake.
- Issues the one-cycle `do_*` micro-op strobes that drive `arith_unit`.
- Writes the result back through a memory write handshake, then reports completion and a status flag.

---
 rtl/arith_ctrl_pkg.sv | 53 +++++
 rtl/arith_ctrl_strobe_dec.sv | 54 +++++
 rtl/arith_ctrl.sv | 159 +++++++++++++++
 tb/tb_arith_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_ctrl_pkg.sv
// Shared encodings for the arith_unit sequencer: op codes, FSM states, strobe bundle.
// ARITH_CTRL_MUL_EN makes OP_MUL a legal command.
package arith_ctrl_pkg;

  localparam int MUL_ITERS_DEFAULT = 30;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_MUL = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_RD1,
    ST_LDA,
    ST_RD2,
    ST_LDB,
    ST_NEGB,
    ST_SUM,
    ST_AND,
    ST_MTEST,
    ST_MSHIFT,
    ST_STB,
    ST_WR,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic do_clear_a;
    logic do_clear_b;
    logic do_clear_c;
    logic do_not_b;
    logic do_sum;
    logic do_and;
    logic do_right_shift_bc;
    logic do_move_c_to_a;
    logic do_move_c_to_b;
    logic do_move_b_to_c;
    logic do_mem_to_c;
  } strobe_t;

  function automatic logic op_legal(input op_e op);
`ifdef ARITH_CTRL_MUL_EN
    op_legal = (op inside {OP_ADD, OP_SUB, OP_AND, OP_MUL});
`else
    op_legal = (op != OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/arith_ctrl_strobe_dec.sv
// Combinational decode of FSM state into arith_unit micro-op strobes and memory requests.
// Only do_mem_to_c (rd_ack) and the multiply-test do_sum (reg_c30) depend on live inputs.
module arith_ctrl_strobe_dec
  import arith_ctrl_pkg::*;
(
  input  state_e  state,
  input  logic    rd_ack,
  input  logic    reg_c30,
  output strobe_t strb,
  output logic    rd_req,
  output logic    rd_sel,
  output logic    wr_req,
  output logic    busy,
  output logic    done
);

  always_comb begin
    strb   = '0;
    rd_req = 1'b0;
    rd_sel = 1'b0;
    wr_req = 1'b0;
    busy   = (state != ST_IDLE);
    done   = 1'b0;
    case (state)
      ST_CLR: begin
        strb.do_clear_a = 1'b1;
        strb.do_clear_b = 1'b1;
        strb.do_clear_c = 1'b1;
      end
      ST_RD1: begin
        rd_req           = 1'b1;
        strb.do_mem_to_c = rd_ack;
      end
      ST_RD2: begin
        rd_req           = 1'b1;
        rd_sel           = 1'b1;
        strb.do_mem_to_c = rd_ack;
      end
      ST_LDA:    strb.do_move_c_to_a    = 1'b1;
      ST_LDB:    strb.do_move_c_to_b    = 1'b1;
      ST_NEGB:   strb.do_not_b          = 1'b1;
      ST_SUM:    strb.do_sum            = 1'b1;
      ST_AND:    strb.do_and            = 1'b1;
      // Add the multiplicand only when the current multiplier bit is set.
      ST_MTEST:  strb.do_sum            = reg_c30;
      ST_MSHIFT: strb.do_right_shift_bc = 1'b1;
      ST_STB:    strb.do_move_b_to_c    = 1'b1;
      ST_WR:     wr_req                 = 1'b1;
      ST_DONE:   done                   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/arith_ctrl.sv
// Command sequencer for arith_unit: operand fetch, micro-op issue, write-back, status.
// Build with ARITH_CTRL_MUL_EN to include the shift-and-add multiply states and counter.
module arith_ctrl
  import arith_ctrl_pkg::*;
#(
  parameter int MUL_ITERS = MUL_ITERS_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] op_sel,
  output logic       busy,
  output logic       done,
  output logic       flag,
  output logic       err,
  output logic       rd_req,
  output logic       rd_sel,
  input  logic       rd_ack,
  output logic       wr_req,
  input  logic       wr_ack,
  input  logic       carry_out,
  input  logic       reg_b0,
  input  logic       reg_c30,
  output logic       do_clear_a,
  output logic       do_clear_b,
  output logic       do_clear_c,
  output logic       do_not_b,
  output logic       do_sum,
  output logic       do_and,
  output logic       do_right_shift_bc,
  output logic       do_move_c_to_a,
  output logic       do_move_c_to_b,
  output logic       do_move_b_to_c,
  output logic       do_mem_to_c
);

  state_e  state_q, state_d;
  op_e     op_q;
  logic    illegal_q;
  logic    flag_q;
  logic    done_int;
  strobe_t strb;

`ifdef ARITH_CTRL_MUL_EN
  localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

  logic [CNT_W-1:0] count_q;
  logic             last_iter;

  assign last_iter = (count_q == CNT_W'(MUL_ITERS - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (state_q == ST_RD2 && rd_ack) begin
      count_q <= '0;
    end else if (state_q == ST_MSHIFT) begin
      count_q <= count_q + CNT_W'(1);
    end
  end
`else
  localparam int unused_iters = MUL_ITERS;
  logic unused_status;
  assign unused_status = reg_b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        op_q      <= op_e'(op_sel);
        illegal_q <= !op_legal(op_e'(op_sel));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = op_legal(op_e'(op_sel)) ? ST_CLR : ST_DONE;
      end
      ST_CLR: state_d = ST_RD1;
      ST_RD1: if (rd_ack) state_d = ST_LDA;
      ST_LDA: state_d = ST_RD2;
      ST_RD2: begin
        if (rd_ack) begin
          case (op_q)
            OP_AND:  state_d = ST_AND;
`ifdef ARITH_CTRL_MUL_EN
            OP_MUL:  state_d = ST_MTEST;
`endif
            default: state_d = ST_LDB;
          endcase
        end
      end
      ST_LDB:    state_d = (op_q == OP_SUB) ? ST_NEGB : ST_SUM;
      ST_NEGB:   state_d = ST_SUM;
      ST_SUM:    state_d = ST_STB;
      ST_AND:    state_d = ST_WR;
`ifdef ARITH_CTRL_MUL_EN
      ST_MTEST:  state_d = ST_MSHIFT;
      ST_MSHIFT: state_d = last_iter ? ST_STB : ST_MTEST;
`endif
      ST_STB:    state_d = ST_WR;
      ST_WR:     if (wr_ack) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Status flag: carry/borrow of the sum, 0 for AND, final b0 for multiply.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      flag_q <= 1'b0;
    end else begin
      case (state_q)
        ST_SUM:    flag_q <= (op_q == OP_SUB) ? ~carry_out : carry_out;
        ST_AND:    flag_q <= 1'b0;
`ifdef ARITH_CTRL_MUL_EN
        ST_MSHIFT: if (last_iter) flag_q <= reg_b0;
`endif
        default: ;
      endcase
    end
  end

  arith_ctrl_strobe_dec u_dec (
    .state   (state_q),
    .rd_ack  (rd_ack),
    .reg_c30 (reg_c30),
    .strb    (strb),
    .rd_req  (rd_req),
    .rd_sel  (rd_sel),
    .wr_req  (wr_req),
    .busy    (busy),
    .done    (done_int)
  );

  assign done              = done_int;
  assign err               = done_int & illegal_q;
  assign flag              = flag_q;
  assign do_clear_a        = strb.do_clear_a;
  assign do_clear_b        = strb.do_clear_b;
  assign do_clear_c        = strb.do_clear_c;
  assign do_not_b          = strb.do_not_b;
  assign do_sum            = strb.do_sum;
  assign do_and            = strb.do_and;
  assign do_right_shift_bc = strb.do_right_shift_bc;
  assign do_move_c_to_a    = strb.do_move_c_to_a;
  assign do_move_c_to_b    = strb.do_move_c_to_b;
  assign do_move_b_to_c    = strb.do_move_b_to_c;
  assign do_mem_to_c       = strb.do_mem_to_c;

endmodule

// File: tb/tb_arith_ctrl.sv
// Bench for arith_ctrl with a behavioural 30-bit arith_unit and a two-word memory.
// Honours ARITH_CTRL_MUL_EN to choose between multiply and illegal-command scenarios.
module tb_arith_ctrl;

  localparam int W = 30;

  typedef struct {
    logic [W-1:0] data;
    logic         flag;
    logic         err;
    int           lat;
    int           rdn;
    int           wrn;
    int           mtc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic [1:0] op_sel = 2'd0;
  logic busy, done, flag, err, rd_req, rd_sel, rd_ack, wr_req, wr_ack;
  logic carry_out, reg_b0, reg_c30;
  logic do_clear_a, do_clear_b, do_clear_c, do_not_b, do_sum, do_and;
  logic do_right_shift_bc, do_move_c_to_a, do_move_c_to_b, do_move_b_to_c, do_mem_to_c;

  always #5 clk = ~clk;

  arith_ctrl #(.MUL_ITERS(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op_sel(op_sel),
    .busy(busy), .done(done), .flag(flag), .err(err),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_ack(wr_ack),
    .carry_out(carry_out), .reg_b0(reg_b0), .reg_c30(reg_c30),
    .do_clear_a(do_clear_a), .do_clear_b(do_clear_b), .do_clear_c(do_clear_c),
    .do_not_b(do_not_b), .do_sum(do_sum), .do_and(do_and),
    .do_right_shift_bc(do_right_shift_bc), .do_move_c_to_a(do_move_c_to_a),
    .do_move_c_to_b(do_move_c_to_b), .do_move_b_to_c(do_move_b_to_c),
    .do_mem_to_c(do_mem_to_c)
  );

  // Behavioural arith_unit: A, B, C registers, carry-in from do_not_b, product carry kept for the shift.
  logic [W-1:0] ra = '0, rb = '0, rc = '0;
  logic         cin = 1'b0, cq = 1'b0;
  logic [W:0]   sum_full;
  logic [W-1:0] mem1 = '0, mem2 = '0;

  assign sum_full  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, cin};
  assign carry_out = sum_full[W];
  assign reg_b0    = rb[0];
  assign reg_c30   = rc[0];

  always @(posedge clk) begin
    if (do_clear_a) ra <= '0;
    else if (do_move_c_to_a) ra <= rc;
    if (do_clear_b) begin
      rb <= '0; cin <= 1'b0; cq <= 1'b0;
    end else if (do_not_b) begin
      rb <= ~rb; cin <= 1'b1;
    end else if (do_sum) begin
      rb <= sum_full[W-1:0]; cq <= sum_full[W]; cin <= 1'b0;
    end else if (do_right_shift_bc) begin
      rb <= {cq, rb[W-1:1]}; cq <= 1'b0;
    end else if (do_move_c_to_b) begin
      rb <= rc;
    end
    if (do_clear_c) rc <= '0;
    else if (do_mem_to_c) rc <= rd_sel ? mem2 : mem1;
    else if (do_and) rc <= ra & rc;
    else if (do_right_shift_bc) rc <= {rb[0], rc[W-1:1]};
    else if (do_move_b_to_c) rc <= rb;
  end

  // Memory handshake with programmable ack delay.
  int rd_delay = 0, wr_delay = 0, rd_wait = 0, wr_wait = 0;
  assign rd_ack = rd_req && (rd_wait >= rd_delay);
  assign wr_ack = wr_req && (wr_wait >= wr_delay);

  always @(posedge clk) begin
    rd_wait <= (rd_req && !rd_ack) ? rd_wait + 1 : 0;
    wr_wait <= (wr_req && !wr_ack) ? wr_wait + 1 : 0;
  end

  // Per-command activity counters, restarted on each accepted start.
  int cyc = 0, start_cyc = 0, rd_cnt = 0, wr_cnt = 0, mtc_cnt = 0, mtc_bad = 0;
  logic [W-1:0] wr_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (resetn && start && !busy) begin
      start_cyc <= cyc;
      rd_cnt <= 0; wr_cnt <= 0; mtc_cnt <= 0; mtc_bad <= 0;
    end else begin
      if (rd_req) rd_cnt <= rd_cnt + 1;
      if (wr_req && wr_ack) begin
        wr_cnt  <= wr_cnt + 1;
        wr_data <= rc;
      end
      if (do_mem_to_c) mtc_cnt <= mtc_cnt + 1;
      if (do_mem_to_c && !rd_ack) mtc_bad <= mtc_bad + 1;
    end
  end

  logic [10:0] strb_vec;
  logic [17:0] outs;
  assign strb_vec = {do_clear_a, do_clear_b, do_clear_c, do_not_b, do_sum, do_and,
                     do_right_shift_bc, do_move_c_to_a, do_move_c_to_b, do_move_b_to_c, do_mem_to_c};
  assign outs = {busy, done, flag, err, rd_req, rd_sel, wr_req, strb_vec};

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  exp_t sb_q[$];
  logic exp_flag = 1'b0;

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int rdd, input int wrd, input logic prev_flag);
    exp_t e;
    logic [63:0] p;
    e.err = 1'b0; e.rdn = 2 + 2 * rdd; e.wrn = 1; e.mtc = 2; e.data = '0; e.flag = 1'b0; e.lat = 0;
    case (op)
      2'd0: begin p = 64'(a) + 64'(b); e.data = p[W-1:0]; e.flag = p[W]; e.lat = 9; end
      2'd1: begin p = 64'(a) - 64'(b); e.data = p[W-1:0]; e.flag = (a < b); e.lat = 10; end
      2'd2: begin e.data = a & b; e.flag = 1'b0; e.lat = 7; end
      default: begin
`ifdef ARITH_CTRL_MUL_EN
        p = 64'(a) * 64'(b); e.data = p[2*W-1:W]; e.flag = p[W-1]; e.lat = 67;
`else
        e.err = 1'b1; e.flag = prev_flag; e.lat = 1; e.rdn = 0; e.wrn = 0; e.mtc = 0;
`endif
      end
    endcase
    if (!e.err) e.lat = e.lat + 2 * rdd + wrd;
    return e;
  endfunction

  // Scoreboard: every done pulse retires the oldest expectation.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check("err", 64'(err), 64'(e.err));
        check("flag", 64'(flag), 64'(e.flag));
        check("latency", 64'(cyc - start_cyc), 64'(e.lat));
        check("rd_cycles", 64'(rd_cnt), 64'(e.rdn));
        check("wr_count", 64'(wr_cnt), 64'(e.wrn));
        check("mem_to_c_count", 64'(mtc_cnt), 64'(e.mtc));
        check("mem_to_c_gate", 64'(mtc_bad), 64'(0));
        check("done_strobes", 64'(strb_vec), 64'(0));
        if (!e.err) check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound);
    for (int n = 0; n < bound; n++) begin
      if (done) return;
      tick();
    end
    check("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int rdd, input int wrd);
    exp_t e;
    mem1 = a; mem2 = b; rd_delay = rdd; wr_delay = wrd;
    e = model(op, a, b, rdd, wrd, exp_flag);
    exp_flag = e.flag;
    sb_q.push_back(e);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int rdd, input int wrd);
    push_cmd(op, a, b, rdd, wrd);
    op_sel = op;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("reset_outputs", 64'(outs), 64'(0));
    resetn = 1'b1;
    tick();
    check("idle_outputs", 64'(outs), 64'(0));

    run_cmd(2'd0, 30'd5, 30'd7, 0, 0);
    run_cmd(2'd0, 30'h3FFF_FFFF, 30'd1, 0, 0);
    run_cmd(2'd1, 30'd7, 30'd5, 0, 0);
    run_cmd(2'd1, 30'd5, 30'd7, 0, 0);
    run_cmd(2'd2, 30'h2AAA_F0F0, 30'h3333_FF00, 0, 0);
`ifdef ARITH_CTRL_MUL_EN
    run_cmd(2'd3, 30'h2000_0000, 30'h2000_0000, 0, 0);
    run_cmd(2'd3, 30'h3FFF_FFFF, 30'h3FFF_FFFF, 1, 1);
    run_cmd(2'd3, 30'h1234_5678, 30'h0ABC_DEF1, 0, 0);
`else
    run_cmd(2'd1, 30'd1, 30'd2, 0, 0);
    op_sel = 2'd3;
    start = 1'b1;
    push_cmd(2'd3, 30'd9, 30'd9, 0, 0);
    tick();
    start = 1'b0;
    check("illegal_done_cycle1", 64'({done, err, rd_req}), 64'(3'b110));
    tick();
`endif

    run_cmd(2'd0, 30'd100, 30'd23, 3, 0);
    run_cmd(2'd1, 30'd40, 30'd2, 0, 2);

    // Held start: second ADD is accepted on the cycle after DONE.
    push_cmd(2'd0, 30'd11, 30'd22, 0, 0);
    push_cmd(2'd0, 30'd11, 30'd22, 0, 0);
    op_sel = 2'd0;
    start = 1'b1;
    tick();
    wait_done(100);
    tick();
    tick();
    start = 1'b0;
    wait_done(100);
    tick();
    check("held_start_drained", 64'(sb_q.size()), 64'(0));

    for (int i = 0; i < 6; i++) begin
      run_cmd(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // Abort while waiting for a read ack.
    mem1 = 30'd1; mem2 = 30'd2; rd_delay = 100; wr_delay = 0;
    op_sel = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("abort_rd_pending", 64'(rd_req), 64'(1));
    resetn = 1'b0;
    tick();
    check("abort_rd_outputs", 64'(outs), 64'(0));
    resetn = 1'b1;
    exp_flag = 1'b0;
    tick();
    run_cmd(2'd0, 30'd1000, 30'd234, 0, 0);

`ifdef ARITH_CTRL_MUL_EN
    mem1 = 30'h2000_0000; mem2 = 30'h1000_0000; rd_delay = 0;
    op_sel = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40 && !do_right_shift_bc; n++) tick();
    check("mshift_reached", 64'(do_right_shift_bc), 64'(1));
    resetn = 1'b0;
    tick();
    check("abort_mshift_outputs", 64'(outs), 64'(0));
    resetn = 1'b1;
    exp_flag = 1'b0;
    tick();
    run_cmd(2'd0, 30'd5, 30'd7, 0, 0);
`endif

    repeat (3) tick();
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
